// File: rtl/mult_ctrl_defs.sv
// Shared definitions for the HI/LO multiply controller.
//   - ex_op codes (3-bit). Values 6 and 7 are not listed and act as NOP.
//   - controller state encodings (2-bit).
//   - operand and product width constants.
package mult_ctrl_defs;

    localparam int DATA_W = 32;
    localparam int PROD_W = 64;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_MTHI = 3'd2;
    localparam logic [2:0] OP_MTLO = 3'd3;
    localparam logic [2:0] OP_MFHI = 3'd4;
    localparam logic [2:0] OP_MFLO = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// EX-stage <-> HI/LO controller bundle.
//   master : pipeline side, drives the EX op and sees stall/read data.
//   slave  : controller side.
// Signals: ex_valid, ex_op[2:0], ex_src1[31:0], ex_src2[31:0], ex_cancel (to
// controller); ex_stall, hilo_rdata[31:0], hi_out[31:0], lo_out[31:0],
// mult_busy (from controller).
interface mult_hilo_ctrl_if;
    import mult_ctrl_defs::*;

    logic              ex_valid;
    logic [2:0]        ex_op;
    logic [DATA_W-1:0] ex_src1;
    logic [DATA_W-1:0] ex_src2;
    logic              ex_cancel;
    logic              ex_stall;
    logic [DATA_W-1:0] hilo_rdata;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    logic              mult_busy;

    modport master (
        output ex_valid, ex_op, ex_src1, ex_src2, ex_cancel,
        input  ex_stall, hilo_rdata, hi_out, lo_out, mult_busy
    );

    modport slave (
        input  ex_valid, ex_op, ex_src1, ex_src2, ex_cancel,
        output ex_stall, hilo_rdata, hi_out, lo_out, mult_busy
    );

endinterface

// File: rtl/mult_hilo_ctrl_multiply.sv
// multiply: iterative signed 32x32 -> 64 shift-add multiplier.
// Ports:
//   clk        in   clock
//   mult_op1   in   signed operand 1 (must stay stable while mult_begin=1)
//   mult_op2   in   signed operand 2 (must stay stable while mult_begin=1)
//   mult_begin in   held high for the whole multiply; dropping it abandons it
//   mult_end   out  product valid this cycle
//   product    out  signed 64-bit result
// The first cycle with mult_begin loads magnitudes; each further cycle retires
// one multiplier bit, so the latency follows the MSB position of |op2|.
// The internal valid clears on the first edge with mult_begin low, so no reset
// port is needed.
module multiply
    import mult_ctrl_defs::*;
(
    input  logic                     clk,
    input  logic signed [DATA_W-1:0] mult_op1,
    input  logic signed [DATA_W-1:0] mult_op2,
    input  logic                     mult_begin,
    output logic                     mult_end,
    output logic signed [PROD_W-1:0] product
);

    logic              vld_p0;
    logic              neg_p0;
    logic [PROD_W-1:0] mcand_p0;
    logic [PROD_W-1:0] acc_p0;
    logic [DATA_W-1:0] mplier_p0;

    // Magnitude as unsigned; the most negative value maps to 2^(DATA_W-1).
    function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] n;
        n = -v;
        abs_mag = v[DATA_W-1] ? $unsigned(n) : $unsigned(v);
    endfunction

    // Load / iterate stage
    always_ff @(posedge clk) begin
        if (!mult_begin) begin
            vld_p0 <= 1'b0;
        end else if (!vld_p0) begin
            vld_p0    <= 1'b1;
            neg_p0    <= mult_op1[DATA_W-1] ^ mult_op2[DATA_W-1];
            mcand_p0  <= {{(PROD_W-DATA_W){1'b0}}, abs_mag(mult_op1)};
            mplier_p0 <= abs_mag(mult_op2);
            acc_p0    <= '0;
        end else if (mplier_p0 != '0) begin
            if (mplier_p0[0])
                acc_p0 <= acc_p0 + mcand_p0;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
        end
    end

    // Result stage (combinational sign restore)
    assign mult_end = vld_p0 & mult_begin & (mplier_p0 == '0);
    assign product  = neg_p0 ? -$signed(acc_p0) : $signed(acc_p0);

endmodule

// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: HI/LO register file and multiply sequencer for the EX stage.
// Ports:
//   clk     in   rising-edge clock
//   resetn  in   synchronous active-low reset
//   bus     slave modport of mult_hilo_ctrl_if (EX op in, stall/HI/LO out)
// States: IDLE accepts MULT; RUN waits for mult_end; GAP is a one-cycle
// settle slot in which HI/LO moves are served but a new MULT waits.
// Build option MULT_HILO_BYPASS_EN: when defined, MFHI/MFLO in the mult_end
// cycle read the product directly instead of stalling into GAP.
module mult_hilo_ctrl
    import mult_ctrl_defs::*;
(
    input  logic            clk,
    input  logic            resetn,
    mult_hilo_ctrl_if.slave bus
);

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] op1_q, op2_q;
    logic [DATA_W-1:0]        hi_q, lo_q;
    logic                     mult_begin, mult_end;
    logic signed [PROD_W-1:0] product;

    logic req, is_mult, is_mthi, is_mtlo, is_mfhi, is_mflo, is_nop;
    logic bypass_ok, stall, served, prod_wr;

    assign mult_begin = (state_q == ST_RUN);

    multiply u_multiply (
        .clk        (clk),
        .mult_op1   (op1_q),
        .mult_op2   (op2_q),
        .mult_begin (mult_begin),
        .mult_end   (mult_end),
        .product    (product)
    );

    assign req     = bus.ex_valid & ~bus.ex_cancel;
    assign is_mult = (bus.ex_op == OP_MULT);
    assign is_mthi = (bus.ex_op == OP_MTHI);
    assign is_mtlo = (bus.ex_op == OP_MTLO);
    assign is_mfhi = (bus.ex_op == OP_MFHI);
    assign is_mflo = (bus.ex_op == OP_MFLO);
    assign is_nop  = ~(is_mult | is_mthi | is_mtlo | is_mfhi | is_mflo);

`ifdef MULT_HILO_BYPASS_EN
    assign bypass_ok = mult_end & (is_mfhi | is_mflo);
`else
    assign bypass_ok = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req & is_mult)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                stall = req & ~is_nop & ~bypass_ok;
                // A cancel aborts the multiply even when it ends this cycle.
                if (bus.ex_cancel | mult_end)
                    state_d = ST_GAP;
            end
            ST_GAP: begin
                stall   = req & is_mult;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign served  = req & ~stall;
    assign prod_wr = (state_q == ST_RUN) & mult_end & ~bus.ex_cancel;

    // A served MF in RUN can only be the bypassed mult_end case.
    always_comb begin
        bus.hilo_rdata = '0;
        if (served & is_mfhi)
            bus.hilo_rdata = (state_q == ST_RUN) ? product[PROD_W-1:DATA_W] : hi_q;
        else if (served & is_mflo)
            bus.hilo_rdata = (state_q == ST_RUN) ? product[DATA_W-1:0] : lo_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) & req & is_mult) begin
                op1_q <= $signed(bus.ex_src1);
                op2_q <= $signed(bus.ex_src2);
            end
            if (prod_wr) begin
                hi_q <= product[PROD_W-1:DATA_W];
                lo_q <= product[DATA_W-1:0];
            end else begin
                if (served & is_mthi)
                    hi_q <= bus.ex_src1;
                if (served & is_mtlo)
                    lo_q <= bus.ex_src1;
            end
        end
    end

    assign bus.ex_stall  = stall;
    assign bus.hi_out    = hi_q;
    assign bus.lo_out    = lo_q;
    assign bus.mult_busy = mult_begin;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl: directed scenarios plus random EX traffic, all
// checked each cycle against a behavioural model of HI/LO and multiply timing.
module tb_mult_hilo_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mult_hilo_ctrl_if bus();

    mult_hilo_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

`ifdef MULT_HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 multiplying, 2 gap.
    int          m_phase = 0;
    int          m_run_idx = 0;
    int          m_end_idx = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_prod = '0;
    bit          last_stall = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // RUN cycle (1-based) in which the product becomes available.
    function automatic int end_cycle(input logic [31:0] op2);
        logic [31:0] mag;
        int k;
        mag = op2[31] ? (32'd0 - op2) : op2;
        if (mag == 0) return 2;
        k = 0;
        for (int i = 0; i < 32; i++)
            if (mag[i]) k = i;
        return k + 3;
    endfunction

    task automatic step(input bit v, input logic [2:0] op, input logic [31:0] s1,
                        input logic [31:0] s2, input bit cancel, input bit rstn);
        bit req, isnop, mend, e_stall, served;
        logic [31:0] e_rdata;
        longint a, b;
        @(negedge clk);
        bus.ex_valid  = v;
        bus.ex_op     = op;
        bus.ex_src1   = s1;
        bus.ex_src2   = s2;
        bus.ex_cancel = cancel;
        resetn        = rstn;
        #1;
        req   = v & ~cancel;
        isnop = !(op >= 3'd1 && op <= 3'd5);
        mend  = (m_phase == 1) && (m_run_idx == m_end_idx);
        if (m_phase == 1)
            e_stall = req && !isnop && !(BYP && mend && (op == 3'd4 || op == 3'd5));
        else if (m_phase == 2)
            e_stall = req && (op == 3'd1);
        else
            e_stall = 1'b0;
        served  = req && !e_stall;
        e_rdata = '0;
        if (served && op == 3'd4) e_rdata = (m_phase == 1) ? m_prod[63:32] : m_hi;
        if (served && op == 3'd5) e_rdata = (m_phase == 1) ? m_prod[31:0] : m_lo;
        check_val("ex_stall", bus.ex_stall, e_stall);
        check_val("hilo_rdata", bus.hilo_rdata, e_rdata);
        check_val("hi_out", bus.hi_out, m_hi);
        check_val("lo_out", bus.lo_out, m_lo);
        check_val("mult_busy", bus.mult_busy, m_phase == 1);
        last_stall = e_stall;
        if (!rstn) begin
            m_phase = 0; m_hi = '0; m_lo = '0;
        end else begin
            case (m_phase)
                0, 2: begin
                    if (m_phase == 0 && served && op == 3'd1) begin
                        m_phase   = 1;
                        m_run_idx = 1;
                        m_end_idx = end_cycle(s2);
                        a = longint'($signed(s1));
                        b = longint'($signed(s2));
                        m_prod = a * b;
                    end else begin
                        m_phase = 0;
                    end
                    if (served && op == 3'd2) m_hi = s1;
                    if (served && op == 3'd3) m_lo = s1;
                end
                default: begin
                    if (cancel) m_phase = 2;
                    else if (mend) begin
                        m_hi = m_prod[63:32]; m_lo = m_prod[31:0]; m_phase = 2;
                    end else m_run_idx++;
                end
            endcase
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         output int n);
        n = 0;
        do begin
            step(1'b1, op, s1, s2, 1'b0, 1'b1);
            n++;
        end while (last_stall && n < 200);
        if (n >= 200) check_val("issue_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    endtask

    // Counts busy cycles after an accepted MULT; returns in the GAP cycle.
    task automatic run_out(output int busy);
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
            if (!bus.mult_busy) break;
            busy++;
        end
    endtask

    int n, busy;
    logic [31:0] sv_hi, sv_lo, r1, r2;

    initial begin
        bus.ex_valid = 0; bus.ex_op = '0; bus.ex_src1 = '0; bus.ex_src2 = '0; bus.ex_cancel = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        idle(2);

        // Basic MULT 3 x -5
        issue(3'd1, 32'd3, 32'hFFFFFFFB, n);
        check_val("basic_accept_cycles", 64'(n), 64'd1);
        run_out(busy);
        check_val("basic_busy_cycles", 64'(busy), 64'd5);
        check_val("basic_hi", bus.hi_out, 32'hFFFFFFFF);
        check_val("basic_lo", bus.lo_out, 32'hFFFFFFF1);
        idle(1);

        // Zero operand
        issue(3'd2, 32'h55AA55AA, 32'd0, n);
        issue(3'd1, 32'h12345678, 32'd0, n);
        run_out(busy);
        check_val("zero_busy_cycles", 64'(busy), 64'd2);
        check_val("zero_hi", bus.hi_out, 32'd0);
        check_val("zero_lo", bus.lo_out, 32'd0);
        idle(1);

        // MFLO right after MULT 7 x 6
        issue(3'd1, 32'd7, 32'd6, n);
        issue(3'd5, 32'd0, 32'd0, n);
        check_val("mflo_rdata", bus.hilo_rdata, 32'd42);
        check_val("mflo_served_in_run", bus.mult_busy, BYP);
        idle(2);

        // MTHI during RUN, then back-to-back MULT presented in GAP
        issue(3'd1, 32'd3, 32'd5, n);
        issue(3'd2, 32'hDEADBEEF, 32'd0, n);
        check_val("mthi_in_gap", bus.mult_busy, 1'b0);
        idle(1);
        check_val("mthi_hi", bus.hi_out, 32'hDEADBEEF);
        check_val("mthi_lo", bus.lo_out, 32'd15);
        issue(3'd1, 32'd9, 32'd9, n);
        for (int i = 0; i < 100 && m_phase != 2; i++) idle(1);
        issue(3'd1, 32'd4, 32'd5, n);
        check_val("b2b_cycles", 64'(n), 64'd2);
        run_out(busy);
        check_val("b2b_lo", bus.lo_out, 32'd20);
        idle(1);

        // Cancel in third RUN cycle
        sv_hi = bus.hi_out; sv_lo = bus.lo_out;
        issue(3'd1, 32'h80000000, 32'h80000000, n);
        idle(2);
        step(1'b1, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        idle(3);
        check_val("cancel_hi", bus.hi_out, sv_hi);
        check_val("cancel_lo", bus.lo_out, sv_lo);
        issue(3'd1, 32'd2, 32'd2, n);
        run_out(busy);
        check_val("after_cancel_hi", bus.hi_out, 32'd0);
        check_val("after_cancel_lo", bus.lo_out, 32'd4);
        idle(1);
        issue(3'd1, 32'h80000000, 32'h80000000, n);
        run_out(busy);
        check_val("minmin_hi", bus.hi_out, 32'h40000000);
        check_val("minmin_lo", bus.lo_out, 32'd0);
        idle(1);

        // Reset mid-run
        issue(3'd1, 32'h7FFFFFFF, 32'h40000000, n);
        idle(3);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle(40);
        check_val("rst_hi", bus.hi_out, 32'd0);
        check_val("rst_lo", bus.lo_out, 32'd0);
        check_val("rst_busy", bus.mult_busy, 1'b0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            r1 = $urandom;
            r2 = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) r2 = 32'd0 - r2;
            step($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), r1, r2,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 99) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
